// File: rtl/tinyalu_cmd_master.sv
`default_nettype none
// ============================================================================
//  Module   : tinyalu_cmd_master
//  Purpose  : Valid/ready command front end for the tinyalu. Issues one ALU
//             operation at a time, bounds the wait for done with a timeout,
//             and returns result, op and status on a valid/ready response port.
//  Options  : define TINYALU_CMD_MASTER_STATS_EN to add the op_count and
//             timeout_count statistics outputs.
//  Revision : 1.0 - initial release
// ============================================================================
module tinyalu_cmd_master #(
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic        clk,
    input  logic        reset,
    // command side
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_a,
    input  logic [7:0]  cmd_b,
    input  logic [2:0]  cmd_op,
    // ALU side
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic [2:0]  alu_op,
    output logic        alu_start,
    input  logic        alu_done,
    input  logic [15:0] alu_result,
`ifdef TINYALU_CMD_MASTER_STATS_EN
    output logic [15:0] op_count,
    output logic [15:0] timeout_count,
`endif
    // response side
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_result,
    output logic [2:0]  rsp_op,
    output logic [1:0]  rsp_status
);

    localparam logic [2:0] c_OP_NOP = 3'b000;
    localparam logic [2:0] c_OP_ADD = 3'b001;
    localparam logic [2:0] c_OP_AND = 3'b010;
    localparam logic [2:0] c_OP_XOR = 3'b011;
    localparam logic [2:0] c_OP_MUL = 3'b100;

    localparam logic [1:0] c_ST_OK      = 2'b00;
    localparam logic [1:0] c_ST_TIMEOUT = 2'b01;
    localparam logic [1:0] c_ST_ILLEGAL = 2'b10;

    // Last value of the wait counter before the timeout fires.
    localparam logic [7:0] c_WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [7:0]  r_alu_a;
    logic [7:0]  r_alu_b;
    logic [2:0]  r_alu_op;
    logic [15:0] r_rsp_result;
    logic [2:0]  r_rsp_op;
    logic [1:0]  r_rsp_status;
    logic [7:0]  r_wait_cnt;

    logic        w_accept;
    logic        w_op_alu;
    logic        w_op_nop;
    logic        w_wait_last;
    logic        w_rsp_xfer;

    assign w_accept    = cmd_valid && (r_state == IDLE);
    assign w_op_alu    = (cmd_op == c_OP_ADD) || (cmd_op == c_OP_AND) ||
                         (cmd_op == c_OP_XOR) || (cmd_op == c_OP_MUL);
    assign w_op_nop    = (cmd_op == c_OP_NOP);
    assign w_wait_last = (r_wait_cnt == c_WAIT_LAST);
    assign w_rsp_xfer  = (r_state == RESP) && rsp_ready;

    assign alu_a      = r_alu_a;
    assign alu_b      = r_alu_b;
    assign alu_op     = r_alu_op;
    assign rsp_result = r_rsp_result;
    assign rsp_op     = r_rsp_op;
    assign rsp_status = r_rsp_status;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        cmd_ready   = 1'b0;
        alu_start   = 1'b0;
        rsp_valid   = 1'b0;
        case (r_state)
            IDLE: begin
                // Held low during reset so nothing is offered to the sender.
                cmd_ready = ~reset;
                if (w_accept) begin
                    w_state_nxt = w_op_alu ? BUSY : RESP;
                end
            end
            BUSY: begin
                alu_start = 1'b1;
                if (alu_done || w_wait_last) begin
                    w_state_nxt = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_alu_a      <= 8'h00;
            r_alu_b      <= 8'h00;
            r_alu_op     <= 3'b000;
            r_rsp_result <= 16'h0000;
            r_rsp_op     <= 3'b000;
            r_rsp_status <= c_ST_OK;
            r_wait_cnt   <= 8'h00;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_rsp_op     <= cmd_op;
                        r_rsp_result <= 16'h0000;
                        r_wait_cnt   <= 8'h00;
                        if (w_op_alu) begin
                            r_alu_a      <= cmd_a;
                            r_alu_b      <= cmd_b;
                            r_alu_op     <= cmd_op;
                            r_rsp_status <= c_ST_OK;
                        end else if (w_op_nop) begin
                            r_rsp_status <= c_ST_OK;
                        end else begin
                            r_rsp_status <= c_ST_ILLEGAL;
                        end
                    end
                end
                BUSY: begin
                    // Done is tested first so it wins a tie with the timeout.
                    if (alu_done) begin
                        r_rsp_result <= alu_result;
                        r_rsp_status <= c_ST_OK;
                    end else if (w_wait_last) begin
                        r_rsp_result <= 16'h0000;
                        r_rsp_status <= c_ST_TIMEOUT;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 8'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef TINYALU_CMD_MASTER_STATS_EN
    logic [15:0] r_op_count;
    logic [15:0] r_timeout_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_op_count      <= 16'h0000;
            r_timeout_count <= 16'h0000;
        end else if (w_rsp_xfer) begin
            if (r_op_count != 16'hFFFF) begin
                r_op_count <= r_op_count + 16'd1;
            end
            if ((r_rsp_status == c_ST_TIMEOUT) && (r_timeout_count != 16'hFFFF)) begin
                r_timeout_count <= r_timeout_count + 16'd1;
            end
        end
    end

    assign op_count      = r_op_count;
    assign timeout_count = r_timeout_count;
`else
    logic w_unused;
    assign w_unused = w_rsp_xfer;
`endif

endmodule
`default_nettype wire

// File: tb/tb_tinyalu_cmd_master.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tinyalu_cmd_master
//  Purpose  : Directed self-checking bench for tinyalu_cmd_master with a
//             behavioural tinyalu whose done latency is set per scenario.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_tinyalu_cmd_master;

    logic        clk       = 1'b0;
    logic        reset     = 1'b1;
    logic        cmd_valid = 1'b0;
    logic [7:0]  cmd_a     = 8'h00;
    logic [7:0]  cmd_b     = 8'h00;
    logic [2:0]  cmd_op    = 3'b000;
    logic        rsp_ready = 1'b1;
    logic        inj_done  = 1'b0;

    logic        cmd_ready;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [2:0]  alu_op;
    logic        alu_start;
    logic        alu_done;
    logic [15:0] alu_result;
    logic        rsp_valid;
    logic [15:0] rsp_result;
    logic [2:0]  rsp_op;
    logic [1:0]  rsp_status;
`ifdef TINYALU_CMD_MASTER_STATS_EN
    logic [15:0] op_count;
    logic [15:0] timeout_count;
`endif

    int n_vec   = 0;
    int n_err   = 0;
    int alu_lat = 0;   // cycles from start rising to done rising; 0 = never
    int m_cnt   = 0;
    logic m_done = 1'b0;

    tinyalu_cmd_master #(.TIMEOUT_CYCLES(15)) dut (
        .clk          (clk),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_a        (cmd_a),
        .cmd_b        (cmd_b),
        .cmd_op       (cmd_op),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_op       (alu_op),
        .alu_start    (alu_start),
        .alu_done     (alu_done),
        .alu_result   (alu_result),
`ifdef TINYALU_CMD_MASTER_STATS_EN
        .op_count     (op_count),
        .timeout_count(timeout_count),
`endif
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_result   (rsp_result),
        .rsp_op       (rsp_op),
        .rsp_status   (rsp_status)
    );

    always #5 clk = ~clk;

    // Behavioural tinyalu: done pulses alu_lat cycles after start rises.
    always @(posedge clk) begin
        if (!alu_start || alu_lat <= 0) begin
            m_cnt  <= 0;
            m_done <= 1'b0;
        end else begin
            m_cnt  <= m_cnt + 1;
            m_done <= ((m_cnt + 1) == alu_lat);
        end
    end

    assign alu_done = m_done | inj_done;

    always @* begin
        alu_result = 16'h0000;
        case (alu_op)
            3'b001:  alu_result = {8'h00, alu_a} + {8'h00, alu_b};
            3'b010:  alu_result = {8'h00, alu_a & alu_b};
            3'b011:  alu_result = {8'h00, alu_a ^ alu_b};
            3'b100:  alu_result = alu_a * alu_b;
            default: alu_result = 16'h0000;
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one command for a single edge; returns in the first cycle after acceptance.
    task automatic send_cmd(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        cmd_a     = a;
        cmd_b     = b;
        cmd_op    = op;
        cmd_valid = 1'b1;
        n_vec++;
        if (cmd_ready !== 1'b1) begin
            n_err++;
            $display("FAIL send_cmd_ready: got %b expected 1", cmd_ready);
        end
        tick();
        cmd_valid = 1'b0;
    endtask

    // lat = cycle (1 = first after acceptance) in which rsp_valid is first seen.
    task automatic wait_rsp(output int lat, output int starts, output bit held);
        logic [18:0] ops;
        bit          first;
        lat    = 1;
        starts = 0;
        held   = 1'b1;
        first  = 1'b1;
        ops    = 19'h0;
        while (rsp_valid !== 1'b1 && lat < 40) begin
            if (alu_start === 1'b1) begin
                starts++;
                if (first) ops = {alu_a, alu_b, alu_op};
                else if ({alu_a, alu_b, alu_op} !== ops) held = 1'b0;
                first = 1'b0;
            end
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        n_vec++; if (cmd_ready !== 1'b0) begin n_err++; $display("FAIL reset_cmd_ready: got %b expected 0", cmd_ready); end
        n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
        n_vec++; if (alu_start !== 1'b0) begin n_err++; $display("FAIL reset_alu_start: got %b expected 0", alu_start); end
        n_vec++; if ({alu_a, alu_b, alu_op} !== 19'h0) begin n_err++; $display("FAIL reset_alu_operands: got %h expected 0", {alu_a, alu_b, alu_op}); end
        n_vec++; if ({rsp_result, rsp_op, rsp_status} !== 21'h0) begin n_err++; $display("FAIL reset_rsp_fields: got %h expected 0", {rsp_result, rsp_op, rsp_status}); end
        reset = 1'b0;
        tick();
        n_vec++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL release_cmd_ready: got %b expected 1", cmd_ready); end
    endtask

    task automatic test_add();
        int lat, starts; bit held;
        alu_lat = 1;
        send_cmd(8'hFF, 8'h01, 3'b001);
        wait_rsp(lat, starts, held);
        n_vec++; if (lat != 3) begin n_err++; $display("FAIL add_latency: got %0d expected 3", lat); end
        n_vec++; if (rsp_result !== 16'h0100) begin n_err++; $display("FAIL add_result: got %h expected 0100", rsp_result); end
        n_vec++; if (rsp_status !== 2'b00) begin n_err++; $display("FAIL add_status: got %b expected 00", rsp_status); end
        n_vec++; if (rsp_op !== 3'b001) begin n_err++; $display("FAIL add_rsp_op: got %b expected 001", rsp_op); end
        n_vec++; if (alu_start !== 1'b0) begin n_err++; $display("FAIL add_start_drop: got %b expected 0", alu_start); end
        tick();
        n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL add_rsp_valid_fall: got %b expected 0", rsp_valid); end
    endtask

    task automatic test_mul();
        int lat, starts; bit held;
        alu_lat = 3;
        send_cmd(8'hFF, 8'hFF, 3'b100);
        wait_rsp(lat, starts, held);
        n_vec++; if (starts != 4) begin n_err++; $display("FAIL mul_start_cycles: got %0d expected 4", starts); end
        n_vec++; if (held !== 1'b1) begin n_err++; $display("FAIL mul_operands_held: got %b expected 1", held); end
        n_vec++; if (lat != 5) begin n_err++; $display("FAIL mul_latency: got %0d expected 5", lat); end
        n_vec++; if (rsp_result !== 16'hFE01) begin n_err++; $display("FAIL mul_result: got %h expected fe01", rsp_result); end
        n_vec++; if (rsp_status !== 2'b00) begin n_err++; $display("FAIL mul_status: got %b expected 00", rsp_status); end
        tick();
    endtask

    task automatic test_timeout();
        int lat, starts; bit held;
        alu_lat = 0;
        send_cmd(8'h12, 8'h34, 3'b001);
        wait_rsp(lat, starts, held);
        n_vec++; if (lat != 16 || starts != 15) begin n_err++; $display("FAIL timeout_busy_cycles: got lat %0d starts %0d expected 16/15", lat, starts); end
        n_vec++; if (rsp_status !== 2'b01) begin n_err++; $display("FAIL timeout_status: got %b expected 01", rsp_status); end
        n_vec++; if (rsp_result !== 16'h0000) begin n_err++; $display("FAIL timeout_result: got %h expected 0000", rsp_result); end
        n_vec++; if (alu_start !== 1'b0) begin n_err++; $display("FAIL timeout_start: got %b expected 0", alu_start); end
        tick();
        inj_done = 1'b1;
        tick();
        inj_done = 1'b0;
        tick();
        n_vec++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin n_err++; $display("FAIL late_done_ignored: got valid %b ready %b expected 0/1", rsp_valid, cmd_ready); end
    endtask

    // Done sampled on the same edge the timeout would fire.
    task automatic test_done_timeout_tie();
        int lat, starts; bit held;
        alu_lat = 14;
        send_cmd(8'h03, 8'h04, 3'b001);
        wait_rsp(lat, starts, held);
        n_vec++; if (lat != 16) begin n_err++; $display("FAIL tie_latency: got %0d expected 16", lat); end
        n_vec++; if (rsp_status !== 2'b00 || rsp_result !== 16'h0007) begin n_err++; $display("FAIL tie_done_wins: got %b/%h expected 00/0007", rsp_status, rsp_result); end
        tick();
    endtask

    task automatic test_nop_illegal();
        int lat, starts; bit held;
        alu_lat = 1;
        send_cmd(8'h55, 8'h66, 3'b000);
        wait_rsp(lat, starts, held);
        n_vec++; if (lat != 1 || starts != 0) begin n_err++; $display("FAIL nop_latency_start: got lat %0d starts %0d expected 1/0", lat, starts); end
        n_vec++; if ({rsp_result, rsp_op, rsp_status} !== {16'h0000, 3'b000, 2'b00}) begin n_err++; $display("FAIL nop_fields: got %h expected 0", {rsp_result, rsp_op, rsp_status}); end
        tick();
        send_cmd(8'h55, 8'h66, 3'b110);
        wait_rsp(lat, starts, held);
        n_vec++; if (lat != 1 || starts != 0 || alu_start !== 1'b0) begin n_err++; $display("FAIL illegal_latency_start: got lat %0d starts %0d expected 1/0", lat, starts); end
        n_vec++; if (rsp_status !== 2'b10) begin n_err++; $display("FAIL illegal_status: got %b expected 10", rsp_status); end
        n_vec++; if (rsp_result !== 16'h0000 || rsp_op !== 3'b110) begin n_err++; $display("FAIL illegal_fields: got %h/%b expected 0000/110", rsp_result, rsp_op); end
        tick();
    endtask

    task automatic test_backpressure();
        int lat, starts; bit held;
        alu_lat   = 1;
        rsp_ready = 1'b0;
        send_cmd(8'hA5, 8'h0F, 3'b011);
        wait_rsp(lat, starts, held);
        cmd_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            n_vec++; if (rsp_valid !== 1'b1 || rsp_result !== 16'h00AA) begin n_err++; $display("FAIL bp_hold_%0d: got %b/%h expected 1/00aa", i, rsp_valid, rsp_result); end
            n_vec++; if (cmd_ready !== 1'b0) begin n_err++; $display("FAIL bp_cmd_ready_%0d: got %b expected 0", i, cmd_ready); end
            tick();
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        tick();
        n_vec++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin n_err++; $display("FAIL bp_release: got valid %b ready %b expected 0/1", rsp_valid, cmd_ready); end
    endtask

    task automatic test_reset_mid_op();
        bit spurious;
        alu_lat = 3;
        send_cmd(8'hFF, 8'hFF, 3'b100);
        tick();
        n_vec++; if (alu_start !== 1'b1) begin n_err++; $display("FAIL mid_busy_start: got %b expected 1", alu_start); end
        #2 reset = 1'b1;
        #1;
        n_vec++; if (alu_start !== 1'b0 || rsp_valid !== 1'b0) begin n_err++; $display("FAIL mid_reset_async: got start %b valid %b expected 0/0", alu_start, rsp_valid); end
        n_vec++; if ({alu_a, alu_b, alu_op} !== 19'h0) begin n_err++; $display("FAIL mid_reset_operands: got %h expected 0", {alu_a, alu_b, alu_op}); end
`ifdef TINYALU_CMD_MASTER_STATS_EN
        n_vec++; if (op_count !== 16'd0 || timeout_count !== 16'd0) begin n_err++; $display("FAIL stats_reset: got %0d/%0d expected 0/0", op_count, timeout_count); end
`endif
        tick();
        reset = 1'b0;
        tick();
        n_vec++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL mid_release_ready: got %b expected 1", cmd_ready); end
        spurious = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (rsp_valid !== 1'b0 || alu_start !== 1'b0) spurious = 1'b1;
            tick();
        end
        n_vec++; if (spurious !== 1'b0) begin n_err++; $display("FAIL mid_reset_no_response: got %b expected 0", spurious); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_mul();
        test_timeout();
        test_done_timeout_tie();
        test_nop_illegal();
        test_backpressure();
`ifdef TINYALU_CMD_MASTER_STATS_EN
        n_vec++; if (op_count !== 16'd7 || timeout_count !== 16'd1) begin n_err++; $display("FAIL stats_counts: got %0d/%0d expected 7/1", op_count, timeout_count); end
`endif
        test_reset_mid_op();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
`default_nettype wire
